prn_check: RTL
==============

Name: prn_check

Overview:
- Receive-side counterpart of prn_gen. Consumes a serial chip stream plus valid strobe, e.g. prn_gen code_out delayed one cycle after sr_shift.
- Regenerates the expected Gold code locally from two programmable 14-bit LFSRs and compares chip by chip.
- Reports error count, chip and epoch progress, and per-epoch lock.
- Used in benches and as a built-in self-check next to the correlator channels.

Parameters:
- W, 14, LFSR width for G1 and G2.
- CW, 16, width of code length, chip counter and error counter.
- EW, 8, width of epoch counters.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; latches configuration and arms the checker.
- init1  in  W  G1 initial state.
- taps1  in  W  G1 feedback tap mask.
- init2  in  W  G2 initial state.
- taps2  in  W  G2 feedback tap mask.
- code_last  in  CW  index of the last chip in an epoch (10229 for a 10230-chip code).
- n_epochs  in  EW  number of epochs to check; 0 means run until next start.
- chip_in  in  1  received chip.
- chip_valid  in  1  chip_in is valid this cycle.
- busy  out  1  high in ARMED or RUN.
- done  out  1  sticky; set on completing n_epochs, cleared by start.
- err_cnt  out  CW  saturating mismatch count since start.
- chip_cnt  out  CW  chip index within the current epoch.
- epoch_cnt  out  EW  completed epochs since start; wraps.
- epoch_err  out  1  one-cycle pulse at epoch end if that epoch had at least one mismatch.
- locked  out  1  set at the end of an epoch with zero mismatches; cleared at the end of an epoch with a mismatch and by start.

Behaviour:
- Reset values: every output is 0. State is IDLE. LFSRs are 0 and configuration registers are 0.
- LFSR step, same for G1 and G2:
  - fb = XOR-reduce(state & taps).
  - next = {fb, state[W-1:1]}.
  - Expected chip = g1[0] ^ g2[0], taken before stepping.
- start, in any state including mid-RUN:
  - Latch init/taps/code_last/n_epochs.
  - Load g1 = init1 and g2 = init2.
  - Clear err_cnt, chip_cnt, epoch_cnt, done, locked and the epoch-mismatch flag.
  - Go to ARMED.
  - A chip_valid in the same cycle as start is ignored.
- FSM:
  - IDLE: wait for start.
  - ARMED: the first chip_valid is compared as chip 0, then go to RUN.
  - RUN: each chip_valid is compared and the LFSRs step. Cycles without chip_valid hold all state.
  - DONE: entered when the epoch completed is number n_epochs (n_epochs≠0). busy=0, done=1, chip_valid is ignored. start returns to ARMED.
- Comparison: mismatch when chip_in ≠ expected. Results register one cycle after chip_valid.
  - err_cnt +1 per mismatch, saturating at 2^CW-1.
  - The epoch-mismatch flag is set.
- Epoch boundary: a valid chip with chip_cnt == code_last.
  - That chip is compared normally.
  - Next cycle: chip_cnt=0, g1/g2 reload init1/init2, epoch_cnt +1.
  - epoch_err pulses if the flag or this last chip mismatched. locked updates, then the flag clears.
  - A mismatch on the last chip counts toward the ending epoch.
- code_last=0 gives a 1-chip epoch: every valid chip is an epoch end.
- Back-to-back chip_valid on every cycle is supported; no bubbles are required.
- Asserting resetn mid-operation returns to IDLE with all outputs 0.

Test Plan:
- Clean match: start with init1=1FFF, taps1=0x0003 (any fixed pair), init2=1B00, taps2=1A00 (G2 mask), code_last=10229, n_epochs=2. Feed a matching reference-model stream with valid every cycle -> err_cnt=0, locked=1 after chip 10229, epoch_cnt=2, done=1, busy=0, no epoch_err.
- Injected errors: same setup, n_epochs=1, flip chips 5, 100 and 10229 -> err_cnt=3, one epoch_err pulse at end of epoch 0, locked=0, done=1.
- Gapped valid: valid on 1 cycle in 3, one epoch -> identical results to the clean case. chip_cnt holds between strobes.
- Saturation: CW=4, stream inverted for 40 chips, n_epochs=0 -> err_cnt stops at 15, busy stays 1.
- Restart mid-run: start at chip 500 with errors already counted -> next cycle err_cnt=0, chip_cnt=0, locked=0. The next valid chip is compared as chip 0 from init values.
- Reset and boundary: resetn low mid-epoch -> all outputs 0, IDLE. With code_last=0, n_epochs=3 and three matching chips -> epoch_cnt=3, done=1.

Source files
------------

// File: rtl/prn_check.sv
// Receive-side Gold-code checker: regenerates the expected chip stream from two
// programmable LFSRs and compares it with the incoming chips, epoch by epoch.
`timescale 1ns/1ps
module prn_check #(
   parameter int W  = 14,
   parameter int CW = 16,
   parameter int EW = 8
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          start,
   input  logic [W-1:0]  init1,
   input  logic [W-1:0]  taps1,
   input  logic [W-1:0]  init2,
   input  logic [W-1:0]  taps2,
   input  logic [CW-1:0] code_last,
   input  logic [EW-1:0] n_epochs,
   input  logic          chip_in,
   input  logic          chip_valid,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] err_cnt,
   output logic [CW-1:0] chip_cnt,
   output logic [EW-1:0] epoch_cnt,
   output logic          epoch_err,
   output logic          locked
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ARMED = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]         state_reg;
   logic [CW-1:0]      code_last_reg;
   logic [EW-1:0]      n_epochs_reg;
   logic [CW-1:0]      err_cnt_reg;
   logic [CW-1:0]      chip_cnt_reg;
   logic [EW-1:0]      epoch_cnt_reg;
   logic               done_reg;
   logic               locked_reg;
   logic               epoch_err_reg;
   logic               ep_flag_reg;

   logic [1:0][W-1:0]  init_in;
   logic [1:0][W-1:0]  taps_in;
   logic [1:0]         g_lsb;
   logic               active;
   logic               chip_take;
   logic               expected;
   logic               mismatch;
   logic               epoch_end;
   logic               epoch_bad;
   logic               last_epoch;
   logic               err_sat;
   logic [EW-1:0]      epoch_inc;

   assign init_in = {init2, init1};
   assign taps_in = {taps2, taps1};

   // start wins over a coincident strobe, so a chip in the start cycle is dropped
   assign active     = (state_reg == S_ARMED) || (state_reg == S_RUN);
   assign chip_take  = chip_valid && active && !start;
   assign expected   = g_lsb[0] ^ g_lsb[1];
   assign mismatch   = chip_take && (chip_in != expected);
   assign epoch_end  = chip_take && (chip_cnt_reg == code_last_reg);
   assign epoch_bad  = ep_flag_reg || mismatch;
   assign epoch_inc  = epoch_cnt_reg + 1'b1;
   assign last_epoch = (n_epochs_reg != '0) && (epoch_inc == n_epochs_reg);
   assign err_sat    = &err_cnt_reg;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_lfsr
         logic [W-1:0] g_reg;
         logic [W-1:0] init_reg;
         logic [W-1:0] taps_reg;
         logic         fb;

         assign fb        = ^(g_reg & taps_reg);
         assign g_lsb[gi] = g_reg[0];

         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               g_reg    <= '0;
               init_reg <= '0;
               taps_reg <= '0;
            end else if (start) begin
               init_reg <= init_in[gi];
               taps_reg <= taps_in[gi];
               g_reg    <= init_in[gi];
            end else if (chip_take) begin
               g_reg <= epoch_end ? init_reg : {fb, g_reg[W-1:1]};
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg     <= S_IDLE;
         code_last_reg <= '0;
         n_epochs_reg  <= '0;
         err_cnt_reg   <= '0;
         chip_cnt_reg  <= '0;
         epoch_cnt_reg <= '0;
         done_reg      <= 1'b0;
         locked_reg    <= 1'b0;
         epoch_err_reg <= 1'b0;
         ep_flag_reg   <= 1'b0;
      end else begin
         epoch_err_reg <= 1'b0;
         if (start) begin
            state_reg     <= S_ARMED;
            code_last_reg <= code_last;
            n_epochs_reg  <= n_epochs;
            err_cnt_reg   <= '0;
            chip_cnt_reg  <= '0;
            epoch_cnt_reg <= '0;
            done_reg      <= 1'b0;
            locked_reg    <= 1'b0;
            ep_flag_reg   <= 1'b0;
         end else if (chip_take) begin
            state_reg <= S_RUN;
            if (mismatch && !err_sat)
               err_cnt_reg <= err_cnt_reg + 1'b1;
            // the last chip's own mismatch still belongs to the ending epoch
            if (epoch_end) begin
               chip_cnt_reg  <= '0;
               epoch_cnt_reg <= epoch_inc;
               epoch_err_reg <= epoch_bad;
               locked_reg    <= !epoch_bad;
               ep_flag_reg   <= 1'b0;
               if (last_epoch) begin
                  state_reg <= S_DONE;
                  done_reg  <= 1'b1;
               end
            end else begin
               chip_cnt_reg <= chip_cnt_reg + 1'b1;
               ep_flag_reg  <= epoch_bad;
            end
         end
      end
   end

   assign busy      = active;
   assign done      = done_reg;
   assign err_cnt   = err_cnt_reg;
   assign chip_cnt  = chip_cnt_reg;
   assign epoch_cnt = epoch_cnt_reg;
   assign epoch_err = epoch_err_reg;
   assign locked    = locked_reg;

endmodule
